// File: rtl/alu_secuencial_if.sv
// rtl/alu_secuencial_if.sv - operand/result handshake bundle for the sequential ALU
interface alu_secuencial_if #(
    parameter int lenD = 8,
    parameter int lenO = 6
);
    logic            in_valid;
    logic            in_ready;
    logic [lenD-1:0] nr1;
    logic [lenD-1:0] nr2;
    logic [lenO-1:0] operacion;
    logic            out_valid;
    logic            out_ready;
    logic [lenD-1:0] resultado;
    logic            zero;
    logic            negative;
    logic            carry;
    logic            overflow;
    logic            invalid_op;

    modport master (
        output in_valid, nr1, nr2, operacion, out_ready,
        input  in_ready, out_valid, resultado, zero, negative, carry, overflow, invalid_op
    );

    modport slave (
        input  in_valid, nr1, nr2, operacion, out_ready,
        output in_ready, out_valid, resultado, zero, negative, carry, overflow, invalid_op
    );
endinterface

// File: rtl/alu_secuencial.sv
// rtl/alu_secuencial.sv - registered handshaked ALU with flags and iterative shift-add MUL
module alu_secuencial #(
    parameter int lenD = 8,
    parameter int lenO = 6
) (
    input logic            clk,
    input logic            reset,
    alu_secuencial_if.slave bus
);
    localparam int CNT_W = $clog2(lenD);
    localparam logic [lenO-1:0] OP_ADD = lenO'(6'b100000);
    localparam logic [lenO-1:0] OP_SUB = lenO'(6'b100010);
    localparam logic [lenO-1:0] OP_AND = lenO'(6'b100100);
    localparam logic [lenO-1:0] OP_OR  = lenO'(6'b100101);
    localparam logic [lenO-1:0] OP_XOR = lenO'(6'b100110);
    localparam logic [lenO-1:0] OP_NOR = lenO'(6'b100111);
    localparam logic [lenO-1:0] OP_SRA = lenO'(6'b000011);
    localparam logic [lenO-1:0] OP_SRL = lenO'(6'b000010);
    localparam logic [lenO-1:0] OP_SLT = lenO'(6'b101010);
    localparam logic [lenO-1:0] OP_MUL = lenO'(6'b011000);
    localparam logic [lenD-1:0] LEN_V  = lenD'(lenD);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q;
    logic            in_ready_q, out_valid_q;
    logic [lenD-1:0] res_q;
    logic            zero_q, negative_q, carry_q, overflow_q, invalid_q;
    logic [lenD-1:0] acc_q, mcand_q, mplier_q;
    logic [CNT_W-1:0] cnt_q;

    logic [lenD-1:0] a, b;
    logic [lenD:0]   sum_ext;
    logic [lenD-1:0] diff;
    logic [lenD-1:0] res_d, acc_d;
    logic            carry_d, overflow_d, invalid_d;

    assign a = bus.nr1;
    assign b = bus.nr2;

    // Single-cycle ops are evaluated on the live operands, so the accept edge latches the answer directly.
    always_comb begin
        sum_ext    = {1'b0, a} + {1'b0, b};
        diff       = a - b;
        res_d      = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        invalid_d  = 1'b0;
        case (bus.operacion)
            OP_ADD: begin
                res_d      = sum_ext[lenD-1:0];
                carry_d    = sum_ext[lenD];
                overflow_d = (a[lenD-1] == b[lenD-1]) && (sum_ext[lenD-1] != a[lenD-1]);
            end
            OP_SUB: begin
                res_d      = diff;
                carry_d    = (a < b);
                overflow_d = (a[lenD-1] != b[lenD-1]) && (diff[lenD-1] != a[lenD-1]);
            end
            OP_AND: res_d = a & b;
            OP_OR:  res_d = a | b;
            OP_XOR: res_d = a ^ b;
            OP_NOR: res_d = ~(a | b);
            OP_SRA: res_d = (b >= LEN_V) ? {lenD{a[lenD-1]}} : lenD'($signed(a) >>> b);
            OP_SRL: res_d = (b >= LEN_V) ? '0 : (a >> b);
            OP_SLT: res_d = {{(lenD-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MUL: res_d = '0;
            default: begin
                res_d     = '1;
                invalid_d = 1'b1;
            end
        endcase
    end

    assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            invalid_q   <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        if (bus.operacion == OP_MUL) begin
                            state_q  <= CALC;
                            acc_q    <= '0;
                            mcand_q  <= a;
                            mplier_q <= b;
                            cnt_q    <= '0;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            res_q       <= res_d;
                            zero_q      <= (res_d == '0);
                            negative_q  <= res_d[lenD-1];
                            carry_q     <= carry_d;
                            overflow_q  <= overflow_d;
                            invalid_q   <= invalid_d;
                        end
                    end
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(lenD - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        res_q       <= acc_d;
                        zero_q      <= (acc_d == '0);
                        negative_q  <= acc_d[lenD-1];
                        carry_q     <= 1'b0;
                        overflow_q  <= 1'b0;
                        invalid_q   <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.resultado  = res_q;
    assign bus.zero       = zero_q;
    assign bus.negative   = negative_q;
    assign bus.carry      = carry_q;
    assign bus.overflow   = overflow_q;
    assign bus.invalid_op = invalid_q;
endmodule

// File: tb/tb_alu_secuencial.sv
// tb/tb_alu_secuencial.sv - vector table, random reference-model run and corner sequences for alu_secuencial
module tb_alu_secuencial;
    localparam int W = 8;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z, n, c, v, inv;
        int         lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_secuencial_if #(.lenD(W), .lenO(6)) bus ();
    alu_secuencial #(.lenD(W), .lenO(6)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        vec_t v;
        int ua, ub, sa, sb, r;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        v.name = "rand"; v.op = op; v.a = a; v.b = b;
        v.c = 1'b0; v.v = 1'b0; v.inv = 1'b0; v.lat = 1;
        case (op)
            6'b100000: begin r = ua + ub; v.c = (r > 255); v.v = (sa + sb > 127) || (sa + sb < -128); end
            6'b100010: begin r = ua - ub; v.c = (ua < ub); v.v = (sa - sb > 127) || (sa - sb < -128); end
            6'b100100: r = ua & ub;
            6'b100101: r = ua | ub;
            6'b100110: r = ua ^ ub;
            6'b100111: r = ~(ua | ub);
            6'b000010: r = (ub >= 8) ? 0 : (ua >> ub);
            6'b000011: r = sa >>> ((ub > 7) ? 7 : ub);
            6'b101010: r = (sa < sb) ? 1 : 0;
            6'b011000: begin r = ua * ub; v.lat = 9; end
            default:   begin r = 255; v.inv = 1'b1; end
        endcase
        v.res = r[7:0];
        v.z = (v.res == 8'h00);
        v.n = v.res[7];
        return v;
    endfunction

    // Starts and ends on a falling edge; out_ready held high so the result transfers on the first DONE edge.
    task automatic do_op(input vec_t v);
        int lat, busy;
        chk({v.name, ":in_ready_pre"}, 32'(bus.in_ready), 32'd1);
        bus.operacion = v.op; bus.nr1 = v.a; bus.nr2 = v.b;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.nr1 = 8'($urandom); bus.nr2 = 8'($urandom); bus.operacion = 6'($urandom);
        lat = 1; busy = 0;
        forever begin
            if (!bus.in_ready) busy++;
            if (bus.out_valid || lat >= 40) break;
            @(negedge clk);
            lat++;
        end
        chk({v.name, ":latency"}, 32'(lat), 32'(v.lat));
        chk({v.name, ":in_ready_low"}, 32'(busy), 32'(v.lat));
        chk({v.name, ":resultado"}, 32'(bus.resultado), 32'(v.res));
        chk({v.name, ":flags_zncvi"},
            32'({bus.zero, bus.negative, bus.carry, bus.overflow, bus.invalid_op}),
            32'({v.z, v.n, v.c, v.v, v.inv}));
        @(negedge clk);
        chk({v.name, ":in_ready_post"}, 32'(bus.in_ready), 32'd1);
        chk({v.name, ":out_valid_post"}, 32'(bus.out_valid), 32'd0);
    endtask

    vec_t tbl[14];
    logic [5:0] ops[11];

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.nr1 = '0; bus.nr2 = '0; bus.operacion = '0;

        tbl[0]  = '{"add_7f_01",   6'b100000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[1]  = '{"sub_03_05",   6'b100010, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[2]  = '{"sub_05_05",   6'b100010, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[3]  = '{"mul_fd_05",   6'b011000, 8'hFD, 8'h05, 8'hF1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9};
        tbl[4]  = '{"mul_10_10",   6'b011000, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9};
        tbl[5]  = '{"sra_80_3",    6'b000011, 8'h80, 8'h03, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[6]  = '{"srl_80_3",    6'b000010, 8'h80, 8'h03, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[7]  = '{"sra_80_9",    6'b000011, 8'h80, 8'h09, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[8]  = '{"srl_80_9",    6'b000010, 8'h80, 8'h09, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[9]  = '{"invalid_3f",  6'b111111, 8'h12, 8'h34, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        tbl[10] = '{"slt_fe_01",   6'b101010, 8'hFE, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[11] = '{"nor_f0_0f",   6'b100111, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[12] = '{"add_ff_01",   6'b100000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[13] = '{"sub_80_01",   6'b100010, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};

        ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                6'b000011, 6'b000010, 6'b101010, 6'b011000, 6'b111111};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset:in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset:out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset:resultado", 32'(bus.resultado), 32'd0);
        chk("reset:flags", 32'({bus.zero, bus.negative, bus.carry, bus.overflow, bus.invalid_op}), 32'd0);

        for (int i = 0; i < 14; i++) do_op(tbl[i]);

        for (int i = 0; i < 150; i++) begin
            logic [5:0] op;
            logic [7:0] a, b;
            vec_t v;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 10)];
            a = 8'($urandom);
            b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            v = model(op, a, b);
            do_op(v);
        end

        // XOR held under backpressure while the inputs are churned
        bus.operacion = 6'b100110; bus.nr1 = 8'hAA; bus.nr2 = 8'h0F;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            bus.nr1 = 8'($urandom); bus.nr2 = 8'($urandom);
            chk("bp:out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp:resultado", 32'(bus.resultado), 32'hA5);
            chk("bp:in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp:released_out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp:released_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk("bp:no_queued_op", 32'(bus.out_valid), 32'd0);

        // Reset landing in the 4th CALC cycle of a MUL
        bus.operacion = 6'b011000; bus.nr1 = 8'hFD; bus.nr2 = 8'h05; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mul:out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mul:resultado", 32'(bus.resultado), 32'd0);
        chk("rst_mul:in_ready", 32'(bus.in_ready), 32'd1);
        do_op('{"add_2_2", 6'b100000, 8'h02, 8'h02, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_secuencial.md
# alu_secuencial

Registered, handshaked successor of the team's combinational 8-bit ALU. It keeps the same funct-style opcode set and adds NOR, SLT and an iterative multi-cycle MUL. Operand width is parametrised, and the block produces status flags. It sits between the operand-loading front end and the result display/UART stage, with valid/ready flow control on both sides.

## Interface
- `lenD`, 8: operand/result width in bits (≥ 4).
- `lenO`, 6: opcode width.
- `clk`  in  1  sole clock; every register updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `in_valid`  in  1  operands and opcode are presented.
- `in_ready`  out  1  block can accept; equals (state == IDLE).
- `nr1`, `nr2`  in  lenD  signed operands.
- `operacion`  in  lenO  opcode.
- `out_valid`  out  1  result and flags are valid.
- `out_ready`  in  1  consumer takes the result.
- `resultado`  out  lenD  registered result.
- `zero`, `negative`, `carry`, `overflow`, `invalid_op`  out  1 each  registered flags.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE→DONE: `in_valid` is high and the opcode is not MUL.
  - IDLE→CALC: `in_valid` is high and the opcode is MUL.
  - CALC→DONE: after the lenD-th iteration.
  - DONE→IDLE: `out_valid && out_ready` at an edge.
- Acceptance happens at the edge where `in_valid && in_ready`. `nr1`, `nr2` and `operacion` are latched at that edge; later input changes are ignored.
- `in_ready` is 0 in CALC and DONE. There is no overlap of operations and no bypass.
- Opcodes:
  - 100000 ADD.
  - 100010 SUB.
  - 100100 AND.
  - 100101 OR.
  - 100110 XOR.
  - 100111 NOR.
  - 000011 SRA (arithmetic shift right).
  - 000010 SRL (logical shift right).
  - 101010 SLT: result is 1 if `nr1 < nr2` signed, else 0.
  - 011000 MUL: low lenD bits of the product. These bits are identical for signed and unsigned two's-complement operands.
- Any other opcode: `resultado` = all ones and `invalid_op` = 1. The operation completes normally through DONE.
- Shift amount is `nr2` taken unsigned, full width. If the amount is ≥ lenD:
  - SRL gives 0.
  - SRA gives lenD copies of the `nr1` sign bit.
- MUL is shift-add:
  - Accumulator is lenD bits; multiplier shifts right and multiplicand shifts left.
  - One iteration per CALC cycle, lenD iterations in total.
- Flags are computed from the final result and latched together with it:
  - `zero` = (resultado == 0); `negative` = resultado[lenD-1].
  - ADD: `carry` = unsigned carry-out; `overflow` = signed overflow (operands have equal signs and the result sign differs).
  - SUB: `carry` = borrow, i.e. `nr1 < nr2` unsigned; `overflow` = signed overflow (operand signs differ and the result sign differs from `nr1`).
  - All other opcodes: `carry` = `overflow` = 0.
- `resultado` and all flags hold stable while `out_valid` = 1 and `out_ready` = 0.

## Timing
- Reset (edge with `reset` = 1):
  - State goes to IDLE; any CALC or DONE in progress is aborted and its result discarded.
  - `out_valid`, `resultado` and all flags go to 0.
  - `in_ready` reads 1 from the cycle after the reset edge, provided `reset` is low.
- Reset has priority over every handshake at the same edge.
- Latency, counted from the acceptance edge:
  - Non-MUL: `out_valid` is high 1 cycle later.
  - MUL: `out_valid` is high lenD+1 cycles later (lenD CALC cycles, then DONE).
- Throughput: a new acceptance is possible at the earliest one cycle after the output transfer edge. This gives 1 op per 2 cycles with `out_ready` tied high.
- `in_valid` while `in_ready` = 0 is ignored; nothing is queued.
- `out_ready` outside DONE has no effect.

## Test plan
- Reset, then ADD 8'h7F + 8'h01 with `out_ready` = 1.
  - Required: `out_valid` high 1 cycle after acceptance; `resultado` = 8'h80; `negative` = 1, `overflow` = 1, `carry` = 0, `zero` = 0.
  - Required: `in_ready` high again the cycle after the transfer.
- SUB 8'h03 − 8'h05, then SUB 8'h05 − 8'h05.
  - First: 8'hFE with `carry` = 1 and `negative` = 1.
  - Second: 8'h00 with `zero` = 1 and `carry` = 0.
- MUL 8'hFD × 8'h05 (−3 × 5).
  - Required: `in_ready` = 0 for 9 cycles; `out_valid` high 9 cycles after acceptance; `resultado` = 8'hF1.
  - Required: MUL 8'h10 × 8'h10 → 8'h00 with `zero` = 1.
- Shifts and invalid opcode:
  - SRA 8'h80 by 3 → 8'hF0; SRL 8'h80 by 3 → 8'h10.
  - SRA 8'h80 by 9 → 8'hFF; SRL by 9 → 8'h00.
  - Opcode 6'b111111 → 8'hFF with `invalid_op` = 1.
- Backpressure: complete an XOR 8'hAA ^ 8'h0F with `out_ready` = 0 for 5 cycles while `nr1`, `nr2` and `in_valid` toggle.
  - Required: `resultado` stays 8'hA5; `in_ready` stays 0; no second acceptance occurs.
- Assert `reset` for 1 cycle in the 4th CALC cycle of a MUL.
  - Required: next cycle `out_valid` = 0, `resultado` = 0 and `in_ready` = 1.
  - Required: a fresh ADD 2 + 2 then returns 8'h04.
